// File: rtl/cpu6_memarb_pkg.sv
// Shared types and constants for the cpu6 single-port memory arbiter.
package cpu6_memarb_pkg;

   // Width of the latency countdown and data-streak registers.
   localparam int unsigned CPU6_MEMARB_CNT_SIZE = 3;

   typedef enum logic {
      StIdle = 1'b0,
      StWait = 1'b1
   } arb_state_e;

   typedef enum logic {
      OwnIf = 1'b0,
      OwnD  = 1'b1
   } arb_owner_e;

   // Saturating increment used for the data-grant streak counter.
   function automatic logic [CPU6_MEMARB_CNT_SIZE-1:0] sat_inc(
      input logic [CPU6_MEMARB_CNT_SIZE-1:0] val,
      input logic [CPU6_MEMARB_CNT_SIZE-1:0] max
   );
      return (val >= max) ? max : val + 1'b1;
   endfunction

endpackage

// File: rtl/cpu6_memarb_dfflr.sv
// Loadable flop with synchronous active-low reset to a parameterised value.
module cpu6_memarb_dfflr #(
   parameter int unsigned     Width    = 1,
   parameter logic [Width-1:0] ResetVal = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   // Reset wins over load; otherwise capture d_i when enabled.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         q_o <= ResetVal;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/cpu6_memarb.sv
// Single-port memory arbiter: fetch vs data, one outstanding access, fixed
// read latency, with a streak limit so fetch cannot be starved by data.
module cpu6_memarb
   import cpu6_memarb_pkg::*;
#(
   parameter int unsigned CPU6_XLEN   = 32,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned MAX_DSTREAK = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_req,
   input  logic [CPU6_XLEN-1:0] if_addr,
   output logic                 if_gnt,
   output logic                 if_valid,
   output logic [CPU6_XLEN-1:0] if_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [CPU6_XLEN-1:0] d_addr,
   input  logic [CPU6_XLEN-1:0] d_wdata,
   output logic                 d_gnt,
   output logic                 d_valid,
   output logic [CPU6_XLEN-1:0] d_rdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [CPU6_XLEN-1:0] mem_addr,
   output logic [CPU6_XLEN-1:0] mem_wdata,
   input  logic [CPU6_XLEN-1:0] mem_rdata
);

   localparam int unsigned CW = CPU6_MEMARB_CNT_SIZE;
   localparam logic [CW-1:0] RdLatCnt  = CW'(RD_LAT);
   localparam logic [CW-1:0] MaxStreak = CW'(MAX_DSTREAK);
   localparam logic [CW-1:0] CntOne    = CW'(1);

   arb_state_e    state_q, state_d;
   arb_owner_e    owner_q, owner_d;
   logic [0:0]    state_raw, owner_raw;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] dstreak_q, dstreak_d;

   logic complete, can_issue, d_win, issue;

   assign state_q = arb_state_e'(state_raw);
   assign owner_q = arb_owner_e'(owner_raw);

   // Arbitration: data wins unless fetch has lost MAX_DSTREAK contested rounds.
   always_comb begin
      complete  = (state_q == StWait) && (cnt_q == CntOne);
      can_issue = reset && ((state_q == StIdle) || complete);
      d_win     = d_req && !(if_req && (dstreak_q == MaxStreak));
      d_gnt     = can_issue && d_win;
      if_gnt    = can_issue && if_req && !d_win;
      issue     = if_gnt || d_gnt;
   end

   // Memory port is driven straight from the winner; zero when idle.
   always_comb begin
      mem_en    = issue;
      mem_we    = d_gnt && d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   // Completion strobes and read data go to the owner of the finishing access.
   always_comb begin
      if_valid = reset && complete && (owner_q == OwnIf);
      d_valid  = reset && complete && (owner_q == OwnD);
      if_rdata = if_valid ? mem_rdata : '0;
      d_rdata  = d_valid ? mem_rdata : '0;
   end

   // Next-state for transaction tracking and the data-streak counter.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      dstreak_d = dstreak_q;
      if (issue) begin
         state_d = StWait;
         owner_d = d_gnt ? OwnD : OwnIf;
         cnt_d   = RdLatCnt;
      end else if (state_q == StWait) begin
         cnt_d = cnt_q - 1'b1;
         if (complete) begin
            state_d = StIdle;
         end
      end
      if (!if_req || if_gnt) begin
         dstreak_d = '0;
      end else if (d_gnt) begin
         dstreak_d = sat_inc(dstreak_q, MaxStreak);
      end
   end

   cpu6_memarb_dfflr #(.Width(1), .ResetVal(1'b0)) u_state_ff (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (1'b1),
      .d_i    (state_d),
      .q_o    (state_raw)
   );

   cpu6_memarb_dfflr #(.Width(1), .ResetVal(1'b0)) u_owner_ff (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (issue),
      .d_i    (owner_d),
      .q_o    (owner_raw)
   );

   cpu6_memarb_dfflr #(.Width(CW), .ResetVal('0)) u_cnt_ff (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (1'b1),
      .d_i    (cnt_d),
      .q_o    (cnt_q)
   );

   cpu6_memarb_dfflr #(.Width(CW), .ResetVal('0)) u_dstreak_ff (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (1'b1),
      .d_i    (dstreak_d),
      .q_o    (dstreak_q)
   );

endmodule

// File: tb/tb_cpu6_memarb.sv
// Randomised bench for cpu6_memarb against a timestamp-based reference model.
module tb_cpu6_memarb;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RDL  = 2;
   localparam int unsigned MAXS = 2;
   localparam int          NCYC = 2500;

   logic            clk = 1'b0;
   logic            reset;
   logic            if_req, if_gnt, if_valid;
   logic [XLEN-1:0] if_addr, if_rdata;
   logic            d_req, d_we, d_gnt, d_valid;
   logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
   logic            mem_en, mem_we;
   logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   cpu6_memarb #(
      .CPU6_XLEN   (XLEN),
      .RD_LAT      (RDL),
      .MAX_DSTREAK (MAXS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_valid  (if_valid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_valid   (d_valid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: the single outstanding access, stamped with its completion cycle.
   bit              pend;
   int              pend_done;
   bit              pend_d, pend_we;
   logic [XLEN-1:0] pend_addr;
   int              streak;
   bit              if_done, d_done;
   logic [XLEN-1:0] fetch_pc;

   function automatic logic [XLEN-1:0] memf(input logic [XLEN-1:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic check_eq(input string tag, input logic [XLEN-1:0] act,
                           input logic [XLEN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h want %h", tag, cyc, act, exp);
      end
   endtask

   task automatic drive_stim(input int c);
      bit contend, fonly;
      reset   = !(c < 2 || c == 1000 || $urandom_range(0, 199) == 0);
      contend = (c >= 2 && c < 40);
      fonly   = (c >= 40 && c < 70);
      if (!reset) begin
         if_req  = 1'b0;
         d_req   = 1'b0;
         if_done = 1'b0;
         d_done  = 1'b0;
         return;
      end
      if (if_done || !if_req) begin
         if_req  = (contend || fonly) ? 1'b1 : ($urandom_range(0, 2) != 0);
         if_addr = fonly ? fetch_pc : ($urandom() & ~32'h3);
         if (fonly) fetch_pc = fetch_pc + 4;
         if_done = 1'b0;
      end else if (!contend && !fonly && $urandom_range(0, 19) == 0) begin
         if_req = 1'b0;
      end
      if (d_done || !d_req) begin
         d_req   = fonly ? 1'b0 : (contend ? 1'b1 : ($urandom_range(0, 2) != 0));
         d_we    = contend ? 1'b0 : 1'($urandom_range(0, 1));
         d_addr  = $urandom() & ~32'h3;
         d_wdata = $urandom();
         d_done  = 1'b0;
      end else if (!contend && $urandom_range(0, 19) == 0) begin
         d_req = 1'b0;
      end
   endtask

   initial begin
      bit comp, free, e_ig, e_dg;
      logic [XLEN-1:0] e_addr;
      reset    = 1'b0;
      if_req   = 1'b0;
      if_addr  = '0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_addr   = '0;
      d_wdata  = '0;
      mem_rdata = '0;
      pend     = 1'b0;
      pend_done = 0;
      pend_d   = 1'b0;
      pend_we  = 1'b0;
      pend_addr = '0;
      streak   = 0;
      if_done  = 1'b0;
      d_done   = 1'b0;
      fetch_pc = 32'h0;
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         drive_stim(c);
         comp = reset && pend && (pend_done == cyc);
         mem_rdata = (comp && !pend_we) ? memf(pend_addr) : $urandom();
         #1;
         free = !pend || (pend_done == cyc);
         e_dg = reset && free && d_req && !(if_req && streak == int'(MAXS));
         e_ig = reset && free && if_req && !e_dg;
         e_addr = e_ig ? if_addr : (e_dg ? d_addr : '0);

         check_eq("if_gnt", 32'(if_gnt), 32'(e_ig));
         check_eq("d_gnt", 32'(d_gnt), 32'(e_dg));
         check_eq("mem_en", 32'(mem_en), 32'(e_ig || e_dg));
         check_eq("mem_we", 32'(mem_we), 32'(e_dg && d_we));
         check_eq("mem_addr", mem_addr, e_addr);
         if (!(e_ig || e_dg)) check_eq("mem_wdata_idle", mem_wdata, '0);
         else if (e_dg && d_we) check_eq("mem_wdata", mem_wdata, d_wdata);
         check_eq("if_valid", 32'(if_valid), 32'(comp && !pend_d));
         check_eq("if_rdata", if_rdata, (comp && !pend_d) ? memf(pend_addr) : '0);
         check_eq("d_valid", 32'(d_valid), 32'(comp && pend_d));
         if (!(comp && pend_d && pend_we))
            check_eq("d_rdata", d_rdata, (comp && pend_d) ? memf(pend_addr) : '0);

         // Advance the model to the state it holds after this rising edge.
         if (!reset) begin
            pend   = 1'b0;
            streak = 0;
         end else begin
            if (comp) pend = 1'b0;
            if (e_ig || e_dg) begin
               pend      = 1'b1;
               pend_done = cyc + int'(RDL);
               pend_d    = e_dg;
               pend_we   = e_dg && d_we;
               pend_addr = e_addr;
            end
            if (!if_req || e_ig) streak = 0;
            else if (e_dg && streak < int'(MAXS)) streak++;
         end
         if_done = e_ig;
         d_done  = e_dg;
         cyc++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
